// File: rtl/pmod_shift_out.sv
// Serial PMOD LED driver: shifts a changed parallel pattern into a 74HC595-style register.
// Define PMOD_SHIFT_LSB_FIRST_EN to shift LSB first (default is MSB first).
module pmod_shift_out #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] din,
   output logic             pmod_sclk,
   output logic             pmod_sdata,
   output logic             pmod_latch,
   output logic             busy
);

   // state | meaning
   // IDLE  | waiting for a forced send or a new pattern
   // SLOW  | shift clock low, current bit presented on sdata
   // SHIGH | shift clock high, external register samples sdata
   // LATCH | storage-register strobe after the last bit

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SLOW, SHIGH, LATCH} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] last_sent;
   logic             force_send;
   logic             cnt_done;
   logic             bit_cur;

   always_comb begin
      cnt_done = (cnt == CNT_LAST);
`ifdef PMOD_SHIFT_LSB_FIRST_EN
      bit_cur  = shreg[idx];
`else
      bit_cur  = shreg[IDX_LAST - idx];
`endif
   end

   // Outputs are decoded from the current state registers, so they trail the state by one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         last_sent  <= '0;
         force_send <= 1'b1;
         pmod_sclk  <= 1'b0;
         pmod_sdata <= 1'b0;
         pmod_latch <= 1'b0;
         busy       <= 1'b0;
      end else begin
         pmod_sclk  <= 1'b0;
         pmod_sdata <= 1'b0;
         pmod_latch <= 1'b0;
         busy       <= 1'b0;
         case (state)
            SLOW: begin
               pmod_sdata <= bit_cur;
               busy       <= 1'b1;
            end
            SHIGH: begin
               pmod_sclk  <= 1'b1;
               pmod_sdata <= bit_cur;
               busy       <= 1'b1;
            end
            LATCH: begin
               pmod_latch <= 1'b1;
               busy       <= 1'b1;
            end
            default: ;
         endcase

         case (state)
            IDLE: begin
               cnt <= '0;
               if (force_send || (din != last_sent)) begin
                  shreg      <= din;
                  force_send <= 1'b0;
                  idx        <= '0;
                  state      <= SLOW;
               end
            end
            SLOW: begin
               if (cnt_done) begin
                  cnt   <= '0;
                  state <= SHIGH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIGH: begin
               if (cnt_done) begin
                  cnt <= '0;
                  if (idx == IDX_LAST) begin
                     state <= LATCH;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SLOW;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LATCH: begin
               if (cnt_done) begin
                  cnt       <= '0;
                  last_sent <= shreg;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pmod_shift_out.md
# pmod_shift_out

Serial PMOD LED driver that sits directly downstream of the free-running LED counter. It takes the counter's 8-bit `pmod_a` pattern and, whenever the pattern changes, shifts it into an external 74HC595-style shift/latch register over three PMOD pins. This lets a single PMOD header drive the LED bank with three wires instead of eight.

## Interface
- `WIDTH`, default 8: number of bits per transfer; must be ≥ 1.
- `CLK_DIV`, default 4: `clk` cycles per `pmod_sclk` half-period and per latch pulse; must be ≥ 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset; release is synchronous to `clk`.
- `din`  in  WIDTH  parallel pattern, connected to the counter's `pmod_a`.
- `pmod_sclk`  out  1  shift clock to the external register.
- `pmod_sdata`  out  1  serial data; stable across each `pmod_sclk` rising edge.
- `pmod_latch`  out  1  storage-register latch strobe, active high.
- `busy`  out  1  high while a transfer is in progress.

## Operation
- Reset values: `pmod_sclk`=0, `pmod_sdata`=0, `pmod_latch`=0, `busy`=0, `last_sent`=0, `force`=1, state=IDLE.
- The FSM has four states: IDLE, SLOW, SHIGH, LATCH.
- **IDLE:** start a transfer when `force` is 1 or `din` != `last_sent`.
  - On start, load `shreg` <= `din` and clear `force`.
  - Go to SLOW with bit index 0.
  - Otherwise remain in IDLE with all outputs 0.
- **SLOW:**
  - `pmod_sclk`=0.
  - `pmod_sdata` = the current bit: MSB first, so bit index 0 is `din[WIDTH-1]`.
  - Hold for CLK_DIV cycles, then go to SHIGH.
- **SHIGH:**
  - `pmod_sclk`=1 and `pmod_sdata` unchanged.
  - Hold for CLK_DIV cycles.
  - If this was the last bit (index WIDTH-1), go to LATCH; otherwise increment the index and go to SLOW.
- **LATCH:**
  - `pmod_sclk`=0, `pmod_sdata`=0, `pmod_latch`=1.
  - Hold for CLK_DIV cycles.
  - Then set `last_sent` <= `shreg` and go to IDLE.
- `busy`=1 in SLOW, SHIGH and LATCH.
- `din` is sampled only in IDLE. Changes during a transfer are ignored until the return to IDLE, where they are compared against the value just sent.
- The divider counter is ⌈log2(CLK_DIV)⌉ bits wide (minimum 1) and wraps to 0 on every state change. The bit index is ⌈log2(WIDTH)⌉ bits wide (minimum 1).
- All outputs are registered; there are no combinational paths from `din` to any output.
- Reset asserted mid-transfer: outputs go to their reset values immediately (asynchronously). The partial transfer is abandoned, and `force`=1 re-sends `din` after release.

## Timing
- Start latency: if the start condition holds in IDLE at edge N, then after edge N+1 `busy`=1 and `pmod_sdata` = MSB.
- Bit cell: 2×CLK_DIV cycles (CLK_DIV low, then CLK_DIV high). The first `pmod_sclk` rise occurs CLK_DIV cycles after `busy` rises.
- Transfer length: `busy` is high for exactly 2×WIDTH×CLK_DIV + CLK_DIV cycles. With defaults this is 68 cycles, of which the latch pulse is the final 4.
- At least 1 IDLE cycle (`busy`=0) separates back-to-back transfers.
- Data setup: `pmod_sdata` is valid ≥ CLK_DIV cycles before each `pmod_sclk` rise. Hold: it stays valid ≥ CLK_DIV cycles after the rise.

## Configuration
- `PMOD_SHIFT_LSB_FIRST_EN` defined: bit index 0 = `din[0]`, so data is shifted LSB first.
- Not defined (default): data is shifted MSB first, as described above.
- No other behaviour or timing changes.

## Test plan
- **Reset release, `din`=0x00:** one forced transfer occurs.
  - 8 sclk rises, each with `sdata`=0.
  - A latch pulse appears on cycles 65–68 of `busy`.
  - After that, `busy` stays 0 while `din` stays 0x00.
- **`din` changes to 0xA5 while idle:**
  - `sdata` sampled at the sclk rises reads 1,0,1,0,0,1,0,1.
  - `busy` is high for exactly 68 cycles.
  - Exactly one latch pulse of 4 cycles.
- **`din` changes 0x01→0x02 mid-transfer:**
  - The current transfer completes with 0x01.
  - A second transfer of 0x02 starts 1 cycle after `busy` falls.
- **`resetn` low during bit 3:** all outputs are 0 in the same cycle. After release, a full transfer of the current `din` occurs.
- **CLK_DIV=1, WIDTH=8, `din`=0xFF:**
  - `busy` is high for 17 cycles.
  - `sclk` toggles every cycle and `sdata`=1 for all 8 rises.
- **`PMOD_SHIFT_LSB_FIRST_EN` defined, `din`=0x01:** the first sampled bit is 1 and the remaining 7 bits are 0.
